// File: rtl/sbox_bank_if.sv
`default_nettype none
// ============================================================================
// Module      : sbox_bank_if
// Description : Load-stream and lookup handshake bundle for the S-box bank.
// Revision    : 1.0 - initial release
// ============================================================================
interface sbox_bank_if #(
    parameter int NSBOX = 8,
    parameter int AW    = 4,
    parameter int DW    = 4
);
    logic                  ld_start;
    logic                  ld_valid;
    logic                  ld_ready;
    logic [NSBOX*DW-1:0]   ld_data;
    logic                  loaded;
    logic                  busy;
    logic                  in_valid;
    logic                  in_ready;
    logic [NSBOX*AW-1:0]   sa;
    logic                  out_valid;
    logic [NSBOX*DW-1:0]   so;

    modport master (
        output ld_start, ld_valid, ld_data, in_valid, sa,
        input  ld_ready, loaded, busy, in_ready, out_valid, so
    );

    modport slave (
        input  ld_start, ld_valid, ld_data, in_valid, sa,
        output ld_ready, loaded, busy, in_ready, out_valid, so
    );
endinterface
`default_nettype wire

// File: rtl/sbox_bank.sv
`default_nettype none
// ============================================================================
// Module      : sbox_bank
// Description : NSBOX GOST S-box tables with a row-streaming loader and a
//               one-cycle registered lookup port.
// Revision    : 1.0 - initial release
// ============================================================================
module sbox_bank #(
    parameter int NSBOX = 8,
    parameter int AW    = 4,
    parameter int DW    = 4
) (
    input wire          clk,
    input wire          rst,
    sbox_bank_if.slave  bus
);
    localparam int            c_depth    = 1 << AW;
    localparam logic [AW-1:0] c_last_row = '1;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [AW-1:0]       r_row;
    logic                r_loaded;
    logic                r_out_valid;
    logic                w_wr;
    logic                w_rd;
    logic                w_done;
    logic [NSBOX*DW-1:0] w_so;

    // A start pulse takes priority over a row presented in the same cycle.
    assign w_wr   = bus.ld_valid && (r_state == LOAD) && !bus.ld_start;
    assign w_rd   = bus.in_valid && (r_state == READY);
    assign w_done = w_wr && (r_row == c_last_row);

    always_comb begin
        w_next = r_state;
        case (r_state)
            EMPTY, READY: begin
                if (bus.ld_start) w_next = LOAD;
            end
            LOAD: begin
                if (bus.ld_start)  w_next = LOAD;
                else if (w_done)   w_next = READY;
            end
            default: w_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= EMPTY;
            r_row       <= '0;
            r_loaded    <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_out_valid <= w_rd;
            if (bus.ld_start)  r_row <= '0;
            else if (w_wr)     r_row <= r_row + 1'b1;
            if (bus.ld_start)  r_loaded <= 1'b0;
            else if (w_done)   r_loaded <= 1'b1;
        end
    end

    generate
        for (genvar i = 0; i < NSBOX; i++) begin : g_sbox
            logic [DW-1:0] r_mem [c_depth];
            logic [DW-1:0] r_q;

            // Table storage carries no reset so it maps onto plain RAM.
            always_ff @(posedge clk) begin
                if (w_wr) r_mem[r_row] <= bus.ld_data[i*DW +: DW];
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst)       r_q <= '0;
                else if (w_rd) r_q <= r_mem[bus.sa[i*AW +: AW]];
            end

            assign w_so[i*DW +: DW] = r_q;
        end
    endgenerate

    assign bus.ld_ready  = (r_state == LOAD);
    assign bus.busy      = (r_state == LOAD);
    assign bus.in_ready  = (r_state == READY);
    assign bus.loaded    = r_loaded;
    assign bus.out_valid = r_out_valid;
    assign bus.so        = w_so;
endmodule
`default_nettype wire

// File: tb/tb_sbox_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_sbox_bank
// Description : Scoreboard bench for sbox_bank (load, lookup, restart, reset).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sbox_bank;
    logic clk;
    logic rst;

    sbox_bank_if #(.NSBOX(8), .AW(4), .DW(4)) bus ();

    sbox_bank #(.NSBOX(8), .AW(4), .DW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] q [$];
    logic [3:0]  mdl [8][16];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] row_data(input int mode, input int r);
        logic [31:0] res;
        int          v;
        res = '0;
        for (int i = 0; i < 8; i++) begin
            case (mode)
                0:       v = r;
                1:       v = r + i;
                2:       v = r * 7 + i * 3 + 5;
                default: v = r ^ (15 - i);
            endcase
            res[i*4 +: 4] = v[3:0];
        end
        return res;
    endfunction

    function automatic logic [31:0] model_lookup(input logic [31:0] a);
        logic [31:0] res;
        for (int i = 0; i < 8; i++) res[i*4 +: 4] = mdl[i][a[i*4 +: 4]];
        return res;
    endfunction

    // Scoreboard consumer: every OUT_VALID must match the oldest pending lookup.
    always @(negedge clk) begin
        if (bus.out_valid === 1'b1) begin
            if (q.size() == 0) chk("spurious out_valid", {31'd0, bus.out_valid}, 32'd0);
            else chk("lookup so", bus.so, q.pop_front());
        end
    end

    task automatic load(input int mode0, input bit thr, input int abort_at,
                        input int mode1, input int exp_cycles);
        int r     = 0;
        int cyc   = 0;
        int mode  = mode0;
        bit abrt  = 1'b0;
        bus.ld_start = 1'b1;
        bus.ld_valid = 1'b0;
        tick();
        bus.ld_start = 1'b0;
        while (r < 16 && cyc < 200) begin
            if (!abrt && r == abort_at) begin
                bus.ld_start = 1'b1;
                bus.ld_valid = 1'b1;
                bus.ld_data  = row_data(mode, r);
                tick();
                bus.ld_start = 1'b0;
                abrt = 1'b1;
                r    = 0;
                mode = mode1;
                chk("restart loaded", {31'd0, bus.loaded}, 32'd0);
                chk("restart busy", {31'd0, bus.busy}, 32'd1);
                continue;
            end
            chk("ld_ready during load", {31'd0, bus.ld_ready}, 32'd1);
            chk("loaded before last row", {31'd0, bus.loaded}, 32'd0);
            bus.ld_valid = thr ? (cyc % 2 == 0) : 1'b1;
            bus.ld_data  = row_data(mode, r);
            tick();
            cyc++;
            if (bus.ld_valid) begin
                for (int i = 0; i < 8; i++) mdl[i][r] = bus.ld_data[i*4 +: 4];
                r++;
            end
        end
        bus.ld_valid = 1'b0;
        chk("rows written", r, 32'd16);
        if (exp_cycles > 0) chk("load cycles", cyc, exp_cycles);
        chk("loaded after load", {31'd0, bus.loaded}, 32'd1);
        chk("busy after load", {31'd0, bus.busy}, 32'd0);
        chk("ld_ready after load", {31'd0, bus.ld_ready}, 32'd0);
        chk("in_ready after load", {31'd0, bus.in_ready}, 32'd1);
    endtask

    task automatic lookup_exp(input logic [31:0] a, input logic [31:0] exp);
        bus.in_valid = 1'b1;
        bus.sa       = a;
        q.push_back(exp);
        tick();
    endtask

    task automatic lookup(input logic [31:0] a);
        lookup_exp(a, model_lookup(a));
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        tick();
    endtask

    task automatic readback_all();
        logic [31:0] a;
        for (int r = 0; r < 16; r++) begin
            a = {8{r[3:0]}};
            lookup(a);
        end
        idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        bus.ld_start = 1'b0;
        bus.ld_valid = 1'b0;
        bus.ld_data  = '0;
        bus.in_valid = 1'b1;
        bus.sa       = '0;
        repeat (3) tick();
        chk("reset ld_ready", {31'd0, bus.ld_ready}, 32'd0);
        chk("reset busy", {31'd0, bus.busy}, 32'd0);
        chk("reset loaded", {31'd0, bus.loaded}, 32'd0);
        chk("reset in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("reset so", bus.so, 32'd0);
        rst = 1'b0;
        tick();
        tick();
        chk("empty in_ready", {31'd0, bus.in_ready}, 32'd0);
        bus.in_valid = 1'b0;
        tick();

        // Identity table, LD_VALID held high.
        load(0, 1'b0, -1, 0, 16);
        lookup_exp(32'h76543210, 32'h76543210);
        idle();
        chk("out_valid drops", {31'd0, bus.out_valid}, 32'd0);
        chk("so holds", bus.so, 32'h76543210);

        // Per-box offset table with back-to-back lookups.
        load(1, 1'b0, -1, 1, 16);
        lookup_exp(32'h00000000, 32'h76543210);
        lookup_exp(32'hFFFFFFFF, 32'h6543210F);
        lookup_exp(32'h11111111, 32'h87654321);
        idle();

        // Throttled load: 16 writes spread over 31 cycles.
        load(2, 1'b1, -1, 2, 31);
        readback_all();

        // Restart at row 9 then full reload with different data.
        load(2, 1'b0, 9, 3, 0);
        readback_all();
        for (int k = 0; k < 6; k++) lookup($urandom);
        idle();

        // Lookup and restart in the same cycle, then reset mid-load.
        bus.in_valid = 1'b1;
        bus.sa       = 32'h01234567;
        q.push_back(model_lookup(32'h01234567));
        bus.ld_start = 1'b1;
        tick();
        bus.ld_start = 1'b0;
        bus.in_valid = 1'b0;
        chk("in_ready after restart", {31'd0, bus.in_ready}, 32'd0);
        chk("busy after restart", {31'd0, bus.busy}, 32'd1);
        chk("loaded after restart", {31'd0, bus.loaded}, 32'd0);
        for (int r = 0; r < 5; r++) begin
            bus.ld_valid = 1'b1;
            bus.ld_data  = row_data(0, r);
            tick();
            chk("in_ready mid reload", {31'd0, bus.in_ready}, 32'd0);
        end
        #3 rst = 1'b1;
        #1;
        chk("async reset busy", {31'd0, bus.busy}, 32'd0);
        chk("async reset ld_ready", {31'd0, bus.ld_ready}, 32'd0);
        chk("async reset loaded", {31'd0, bus.loaded}, 32'd0);
        chk("async reset in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("async reset out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("async reset so", bus.so, 32'd0);
        bus.ld_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chk("post reset busy", {31'd0, bus.busy}, 32'd0);
        chk("post reset in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("post reset loaded", {31'd0, bus.loaded}, 32'd0);

        repeat (3) tick();
        chk("scoreboard drained", q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/sbox_bank.md
Name: sbox_bank

Overview:
- Parametrised S-box memory bank for the GOST 28147-89 round function: NSBOX independent lookup tables, each with 2^AW entries of DW bits.
- Built-in load sequencer: streams one table row per handshake, with the row address shared by all tables and auto-incremented internally. The core no longer drives a common address.
- Lookup port has a valid/ready handshake and registered output.
- Sits between the key/S-box loader and the round datapath.

Parameters:
- NSBOX, 8, number of S-boxes (lookup channels).
- AW, 4, address bits per S-box; depth = 2^AW.
- DW, 4, data bits per S-box entry.

Ports:
- CLK  in  1  clock, all state on rising edge.
- RST  in  1  asynchronous active-high reset.
- LD_START  in  1  pulse; begins (or restarts) a full table load at row 0.
- LD_VALID  in  1  load row present on LD_DATA.
- LD_READY  out  1  bank accepts a load row.
- LD_DATA  in  NSBOX*DW  row data; slice [i*DW+DW-1:i*DW] written to S-box i.
- LOADED  out  1  all 2^AW rows written since last start/reset.
- BUSY  out  1  load in progress.
- IN_VALID  in  1  lookup request.
- IN_READY  out  1  bank accepts a lookup.
- SA  in  NSBOX*AW  per-S-box addresses; slice i addresses S-box i.
- OUT_VALID  out  1  SO holds a lookup result.
- SO  out  NSBOX*DW  lookup result; slice i from S-box i.

Behaviour:
- Storage:
  - NSBOX synchronous RAMs, each 2^AW x DW, with one shared row-address write port and independent read addresses.
  - RAM contents are not reset.
- FSM states: EMPTY, LOAD, READY.
  - Reset enters EMPTY.
- Transitions:
  - EMPTY/READY -> LOAD on LD_START.
  - LOAD -> LOAD on LD_START: row counter returns to 0, LOADED stays 0.
  - LOAD -> READY when a handshake completes at row counter = 2^AW-1 and LD_START is low.
- Load handshake:
  - LD_READY = (state==LOAD); BUSY = (state==LOAD).
  - A write occurs when LD_VALID & LD_READY & !LD_START. Every S-box i is written at row = row counter with its LD_DATA slice.
  - Row counter is AW bits, increments per write, and wraps to 0 after the last row.
  - LD_VALID while not in LOAD is ignored.
- LOADED:
  - Registered; set on entering READY.
  - Cleared on LD_START and on reset.
- Lookup handshake:
  - IN_READY = (state==READY). It is combinational from state only, not from IN_VALID.
  - On IN_VALID & IN_READY, every S-box reads its SA slice.
  - Next cycle: OUT_VALID=1 and SO=read data. Latency is exactly 1 cycle, with throughput 1 lookup/cycle.
  - Cycle with no accepted lookup: OUT_VALID=0 next cycle; SO holds its last value.
- Simultaneous LD_START and accepted lookup in READY:
  - The lookup completes normally from the old contents (OUT_VALID next cycle).
  - The FSM moves to LOAD in the same edge.
- There is no backpressure on the output: the consumer must always accept OUT_VALID.
- Reset values: LD_READY=0, BUSY=0, LOADED=0, IN_READY=0, OUT_VALID=0, SO=0, row counter=0, state=EMPTY.
- Reset mid-load:
  - Immediate return to EMPTY.
  - Partially written rows remain in RAM but are unusable until a full reload.
- Width rules:
  - LD_DATA/SO width NSBOX*DW; SA width NSBOX*AW.
  - No arithmetic other than the AW-bit row counter.

Test Plan:
- Reset: assert RST mid-cycle (asynchronous) -> all outputs 0 immediately, IN_READY=0, IN_VALID ignored.
- Identity load, defaults:
  - Stimulus: LD_START, then 16 rows with row r = {8{r[3:0]}}, LD_VALID held high.
  - Expect: LD_READY high for exactly 16 cycles, then LOADED=1, BUSY=0.
  - Follow-up: lookup SA=32'h76543210 -> one cycle later OUT_VALID=1, SO=32'h76543210.
- Per-box independence:
  - Stimulus: load row r with S-box i entry = (r+i) mod 16; lookup SA=32'h00000000.
  - Expect: SO=32'h76543210.
  - Back-to-back lookups of SA=32'hFFFFFFFF then 32'h11111111 -> SO=32'h6543210F then 32'h87654321 on consecutive cycles.
- Load throttling:
  - Stimulus: LD_VALID toggled every other cycle.
  - Expect: exactly 16 writes, LOADED only after the 16th, counter never skips rows (verify by full readback of all 16 rows).
- Restart:
  - Stimulus: LD_START at row 9 of a load.
  - Expect: counter returns to 0 and LOADED stays 0. A subsequent complete 16-row load with new data -> all lookups return the new data.
- Simultaneous events:
  - Stimulus: in READY, IN_VALID and LD_START in the same cycle.
  - Expect: OUT_VALID=1 next cycle with old data; IN_READY=0 from the next cycle until the reload completes.
  - Reset during that load -> LOADED=0, state EMPTY.
